// File: rtl/jk_bank_sequencer.sv
// rtl/jk_bank_sequencer.sv - command sequencer driving an external JK flip-flop bank
module jk_bank_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] steps_left
);

    typedef enum logic [1:0] {IDLE, EXEC, SETTLE, DONE} state_t;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_UP    = 2'b10;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] steps_q;
    logic             accept;
    logic             is_count;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_down;
    logic             acc_up;
    logic             acc_down;

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign steps_left = steps_q;
    assign accept     = cmd_valid && cmd_ready;
    // op[1] set means count up or count down
    assign is_count   = op_q[1];

    // State register; reset returns to IDLE so j/k drop to zero immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command latch and step counter; steps tick down on the edge leaving EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_CLEAR;
            data_q  <= '0;
            steps_q <= '0;
        end else if (accept) begin
            op_q    <= cmd_op;
            data_q  <= cmd_data;
            steps_q <= cmd_op[1] ? cmd_data : '0;
        end else if (state == EXEC && is_count) begin
            steps_q <= steps_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_op[1] && cmd_data == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = EXEC;
                    end
                end
            end
            EXEC:   state_nxt = SETTLE;
            SETTLE: begin
                if (is_count && steps_q != '0) begin
                    state_nxt = EXEC;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Toggle masks: a bit flips when every lower bit is 1 (up) or 0 (down)
    always_comb begin
        t_up     = '0;
        t_down   = '0;
        acc_up   = 1'b1;
        acc_down = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t_up[i]   = acc_up;
            t_down[i] = acc_down;
            acc_up    = acc_up & q_in[i];
            acc_down  = acc_down & ~q_in[i];
        end
    end

    // Bank drive: only EXEC presents a non-hold code to the flip-flops
    always_comb begin
        j_out = '0;
        k_out = '0;
        if (state == EXEC) begin
            case (op_q)
                OP_CLEAR: begin
                    j_out = '0;
                    k_out = '1;
                end
                OP_LOAD: begin
                    j_out = data_q;
                    k_out = ~data_q;
                end
                OP_UP: begin
                    j_out = t_up;
                    k_out = t_up;
                end
                default: begin
                    j_out = t_down;
                    k_out = t_down;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb/tb_jk_bank_sequencer.sv - randomized self-checking bench for jk_bank_sequencer
module tb_jk_bank_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_data = '0;
    logic [W-1:0] q_bank = 4'b1010;
    logic [W-1:0] j_out;
    logic [W-1:0] k_out;
    logic         busy;
    logic         done;
    logic [W-1:0] steps_left;

    int vectors = 0;
    int errors  = 0;
    int done_cnt = 0;
    logic [W-1:0] q_m = 4'b1010;

    jk_bank_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .q_in(q_bank),
        .j_out(j_out), .k_out(k_out), .busy(busy), .done(done),
        .steps_left(steps_left)
    );

    always #5 clk = ~clk;

    // External JK bank: Q+ = J & ~Q | ~K & Q
    always @(posedge clk) q_bank <= (j_out & ~q_bank) | (~k_out & q_bank);

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    // Issue one command and check every cycle until it completes against the
    // arithmetic model; optionally keep cmd_valid high with a follow-up command.
    task automatic drive_cmd(input logic [1:0] op, input logic [W-1:0] data,
                             input bit hold, input logic [1:0] nop,
                             input logic [W-1:0] ndata);
        int last;
        int start_done;
        int waited;
        logic [W-1:0] ej, ek, nq;
        bit exec;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: cmd_ready=%b required 1", cmd_ready);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        start_done = done_cnt;
        last = op[1] ? 2 * int'(data) + 1 : 3;
        @(posedge clk);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (hold) begin
                    cmd_op   = nop;
                    cmd_data = ndata;
                end else begin
                    cmd_valid = 1'b0;
                    cmd_op    = 2'($urandom);
                    cmd_data  = W'($urandom);
                end
            end
            exec = (c % 2 == 1) && (c < last);
            ej = '0;
            ek = '0;
            nq = q_m;
            if (exec) begin
                case (op)
                    2'b00: begin ej = '0; ek = '1; nq = '0; end
                    2'b01: begin ej = data; ek = ~data; nq = data; end
                    2'b10: begin nq = q_m + 1'b1; ej = q_m ^ nq; ek = ej; end
                    default: begin nq = q_m - 1'b1; ej = q_m ^ nq; ek = ej; end
                endcase
            end
            vectors++;
            if (j_out !== ej || k_out !== ek) begin
                errors++;
                $display("FAIL jk op=%b c=%0d: j=%b k=%b required j=%b k=%b",
                         op, c, j_out, k_out, ej, ek);
            end
            vectors++;
            if (busy !== 1'b1 || cmd_ready !== 1'b0 || done !== (c == last)) begin
                errors++;
                $display("FAIL status op=%b c=%0d: busy=%b ready=%b done=%b required 1 0 %b",
                         op, c, busy, cmd_ready, done, (c == last));
            end
            vectors++;
            if (steps_left !== (op[1] ? W'(int'(data) - c / 2) : W'(0))) begin
                errors++;
                $display("FAIL steps op=%b c=%0d: steps_left=%0d required %0d", op, c,
                         steps_left, (op[1] ? W'(int'(data) - c / 2) : W'(0)));
            end
            if (exec) q_m = nq;
            if (c % 2 == 0 || c == last) begin
                vectors++;
                if (q_bank !== q_m) begin
                    errors++;
                    $display("FAIL bank op=%b c=%0d: q=%b required %b", op, c, q_bank, q_m);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || done_cnt != start_done + 1) begin
            errors++;
            $display("FAIL finish op=%b: busy=%b ready=%b dones=%0d required 0 1 1",
                     op, busy, cmd_ready, done_cnt - start_done);
        end
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || steps_left !== '0 ||
            j_out !== '0 || k_out !== '0) begin
            errors++;
            $display("FAIL reset: ready=%b busy=%b done=%b steps=%0d j=%b k=%b required 1 0 0 0 0000 0000",
                     cmd_ready, busy, done, steps_left, j_out, k_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clear();
        drive_cmd(2'b00, 4'b1011, 1'b0, 2'b00, '0);
    endtask

    task automatic test_load();
        drive_cmd(2'b01, 4'b0110, 1'b0, 2'b00, '0);
    endtask

    task automatic test_count_up_wrap();
        drive_cmd(2'b01, 4'b1110, 1'b0, 2'b00, '0);
        drive_cmd(2'b10, 4'd3, 1'b0, 2'b00, '0);
    endtask

    task automatic test_count_down_zero();
        drive_cmd(2'b01, 4'b0001, 1'b0, 2'b00, '0);
        drive_cmd(2'b11, 4'd2, 1'b0, 2'b00, '0);
        drive_cmd(2'b11, 4'd0, 1'b0, 2'b00, '0);
        vectors++;
        if (q_bank !== 4'b1111) begin
            errors++;
            $display("FAIL zero_step_q: q=%b required 1111", q_bank);
        end
    endtask

    task automatic test_back_to_back();
        drive_cmd(2'b10, 4'd2, 1'b1, 2'b01, 4'b1001);
        drive_cmd(2'b01, 4'b1001, 1'b0, 2'b00, '0);
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [W-1:0] d;
        for (int n = 0; n < 25; n++) begin
            op = 2'($urandom);
            d  = op[1] ? W'($urandom_range(0, 6)) : W'($urandom);
            drive_cmd(op, d, 1'b0, 2'b00, '0);
        end
    endtask

    task automatic test_reset_mid();
        int start_done;
        drive_cmd(2'b01, 4'b0011, 1'b0, 2'b00, '0);
        start_done = done_cnt;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_data  = 4'd5;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        vectors++;
        if (j_out !== 4'b0111 || k_out !== 4'b0111) begin
            errors++;
            $display("FAIL mid_exec: j=%b k=%b required 0111 0111", j_out, k_out);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (j_out !== '0 || k_out !== '0 || cmd_ready !== 1'b1 || busy !== 1'b0 ||
            steps_left !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: j=%b k=%b ready=%b busy=%b steps=%0d done=%b required 0000 0000 1 0 0 0",
                     j_out, k_out, cmd_ready, busy, steps_left, done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (done_cnt != start_done || q_bank !== 4'b0011 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: dones=%0d q=%b busy=%b required 0 0011 0",
                     done_cnt - start_done, q_bank, busy);
        end
        q_m = q_bank === 4'b0011 ? 4'b0011 : q_bank;
    endtask

    initial begin
        test_reset();
        test_clear();
        test_load();
        test_count_up_wrap();
        test_count_down_zero();
        test_back_to_back();
        test_random();
        test_reset_mid();
        drive_cmd(2'b11, 4'd1, 1'b0, 2'b00, '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
